// File: rtl/vga_frame_loader.sv
// vga_frame_loader: round-robin arbiter that latches a 64-bit frame from one of two
// requesters and streams it to the VGA instruction port as LD0..LD7 byte loads.
module vga_frame_loader #(
   parameter int ISSUE_GAP = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [63:0] req0_frame,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [63:0] req1_frame,
   input  logic        req1_valid,
   output logic        req1_ready,
   output logic [11:0] inst,
   output logic        inst_en,
   output logic        busy,
   output logic        grant_id,
   output logic        frame_done
);
   localparam int GW = ISSUE_GAP > 0 ? $clog2(ISSUE_GAP + 1) : 1;
   localparam logic [GW-1:0] GAP_LOAD = GW'(ISSUE_GAP > 0 ? ISSUE_GAP - 1 : 0);
   typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
   state_t      state_q;
   logic [63:0] frame_q;
   logic [2:0]  idx_q;
   logic [GW-1:0] gap_q;
   logic        last_q, grant_q, busy_q, done_q, en_q;
   logic [11:0] inst_q;
   logic        g0_d, g1_d;
   logic [2:0]  idx_d;
   logic [11:0] inst_d;
   // last_q holds the previous winner, so a tie goes to the other requester
   assign g0_d = !reset && state_q == IDLE && req0_valid && (!req1_valid || last_q);
   assign g1_d = !reset && state_q == IDLE && req1_valid && (!req0_valid || !last_q);
   assign idx_d = idx_q + 3'd1;
   assign inst_d = {{1'b0, idx_d} + 4'd1, frame_q[{idx_d, 3'b000} +: 8]};
   assign req0_ready = g0_d;
   assign req1_ready = g1_d;
   assign inst = inst_q;
   assign inst_en = en_q;
   assign busy = busy_q;
   assign grant_id = grant_q;
   assign frame_done = done_q;
   always_ff @(posedge clock) begin
      if (reset || !(state_q inside {IDLE, ISSUE, GAP})) begin
         state_q <= IDLE;
         frame_q <= '0;
         idx_q   <= '0;
         gap_q   <= '0;
         last_q  <= 1'b1;
         grant_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         en_q    <= 1'b0;
         inst_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               en_q   <= 1'b0;
               inst_q <= '0;
               done_q <= 1'b0;
               if (g0_d || g1_d) begin
                  frame_q <= g1_d ? req1_frame : req0_frame;
                  grant_q <= g1_d;
                  last_q  <= g1_d;
                  busy_q  <= 1'b1;
                  idx_q   <= '0;
                  inst_q  <= {4'h1, g1_d ? req1_frame[7:0] : req0_frame[7:0]};
                  en_q    <= 1'b1;
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               if (idx_q == 3'd7) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  en_q    <= 1'b0;
                  inst_q  <= '0;
                  done_q  <= 1'b0;
               end else if (ISSUE_GAP > 0) begin
                  state_q <= GAP;
                  gap_q   <= GAP_LOAD;
                  en_q    <= 1'b0;
                  inst_q  <= '0;
                  done_q  <= 1'b0;
               end else begin
                  idx_q  <= idx_d;
                  inst_q <= inst_d;
                  en_q   <= 1'b1;
                  done_q <= idx_d == 3'd7;
               end
            end
            GAP: begin
               if (gap_q == '0) begin
                  state_q <= ISSUE;
                  idx_q   <= idx_d;
                  inst_q  <= inst_d;
                  en_q    <= 1'b1;
                  done_q  <= idx_d == 3'd7;
               end else begin
                  gap_q <= gap_q - 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vga_frame_loader.sv
// tb_vga_frame_loader: randomized scoreboard bench; the driver predicts each accepted
// frame's LD stream with cycle stamps and a monitor pops and compares every issue.
module tb_vga_frame_loader;
   localparam int G = 2;
   logic        clock = 1'b0, reset = 1'b1;
   logic [63:0] f0 = '0, f1 = '0;
   logic        v0 = 1'b0, v1 = 1'b0;
   logic        r0, r1, inst_en, busy, grant_id, frame_done;
   logic [11:0] inst;
   typedef struct {int cyc; logic [11:0] inst; logic id; logic done;} exp_t;
   exp_t sb[$];
   int   cyc = 0, n_pass = 0, n_chk = 0;
   int   busy_from = 1, busy_until = 0, free_at = 0, accepted = 0;
   logic rst_seen = 1'b1, last_m = 1'b1;
   bit   done_sim = 0;

   vga_frame_loader #(.ISSUE_GAP(G)) dut (
      .clock(clock), .reset(reset),
      .req0_frame(f0), .req0_valid(v0), .req0_ready(r0),
      .req1_frame(f1), .req1_valid(v1), .req1_ready(r1),
      .inst(inst), .inst_en(inst_en), .busy(busy), .grant_id(grant_id), .frame_done(frame_done)
   );

   always #5 clock = ~clock;
   always @(posedge clock) begin
      cyc <= cyc + 1;
      rst_seen <= reset;
   end

   task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
   endtask

   // monitor: compares what the DUT presents against the scoreboard queue
   always @(negedge clock) begin
      exp_t e;
      if (!done_sim) begin
         if (rst_seen) begin
            chk({inst_en, inst, busy, frame_done, grant_id} == '0, "reset_state",
                {inst_en, inst, busy, frame_done, grant_id}, 0);
         end else begin
            if (inst_en) begin
               chk(inst[11:8] >= 4'd1 && inst[11:8] <= 4'd8, "opcode_legal", inst[11:8], 1);
               if (sb.size() == 0) chk(0, "unexpected_ld", inst, 0);
               else begin
                  e = sb.pop_front();
                  chk(e.cyc == cyc, "ld_cycle", cyc, e.cyc);
                  chk(inst == e.inst, "inst", inst, e.inst);
                  chk({grant_id, frame_done} == {e.id, e.done}, "id_done",
                      {grant_id, frame_done}, {e.id, e.done});
               end
            end else begin
               chk(inst == 0 && frame_done == 0, "quiet_out", {inst, frame_done}, 0);
               if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                  chk(0, "missed_ld", sb[0].inst, sb[0].cyc);
                  void'(sb.pop_front());
               end
            end
            if (!reset) chk(busy == (cyc >= busy_from && cyc <= busy_until), "busy", busy,
                            cyc >= busy_from && cyc <= busy_until);
         end
      end
   end

   // driver and reference model
   initial begin
      logic er0, er1, a0, a1;
      logic [63:0] fr;
      bit   do_rst = 0, rst_done = 0;
      int   rst_cnt = 0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      v0 = 1'b1; f0 = 64'h8877665544332211;
      v1 = 1'b1; f1 = {$urandom, $urandom};
      while (accepted < 1000 && cyc < 60000) begin
         @(negedge clock);
         er0 = !reset && cyc >= free_at && v0 && (!v1 || last_m);
         er1 = !reset && cyc >= free_at && v1 && (!v0 || !last_m);
         chk({r0, r1} == {er0, er1}, "ready", {r0, r1}, {er0, er1});
         a0 = v0 && r0;
         a1 = v1 && r1;
         if (er0 || er1) begin
            fr = er1 ? f1 : f0;
            for (int k = 0; k < 8; k++)
               sb.push_back('{cyc + 1 + k * (G + 1), {4'(k + 1), fr[8 * k +: 8]}, er1, k == 7});
            busy_from = cyc + 1;
            busy_until = cyc + 8 + 7 * G;
            free_at = busy_until + 1;
            last_m = er1;
            accepted++;
         end
         if (!rst_done && accepted >= 20 && inst_en && inst[11:8] == 4'd4) do_rst = 1;
         @(posedge clock);
         #1;
         if (do_rst) begin
            reset = 1'b1;
            rst_cnt = 3;
            sb.delete();
            busy_from = 1; busy_until = 0; free_at = 0; last_m = 1'b1;
            do_rst = 0; rst_done = 1;
         end else if (rst_cnt > 0) begin
            rst_cnt--;
            if (rst_cnt == 0) reset = 1'b0;
         end
         if (accepted < 4) begin
            v0 = 1'b1; v1 = 1'b1;
            if (a0) f0 = {$urandom, $urandom};
            if (a1) f1 = {$urandom, $urandom};
         end else begin
            if (a0 || !v0) begin v0 = 1'($urandom % 2); f0 = {$urandom, $urandom}; end
            else if ($urandom % 4 == 0) f0 = {$urandom, $urandom};
            if (a1 || !v1) begin v1 = 1'($urandom % 2); f1 = {$urandom, $urandom}; end
            else if ($urandom % 4 == 0) f1 = {$urandom, $urandom};
         end
      end
      if (accepted < 1000) chk(0, "cycle_budget", accepted, 1000);
      v0 = 1'b0; v1 = 1'b0;
      for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clock);
      @(negedge clock);
      chk(sb.size() == 0 && !busy, "drain", sb.size(), 0);
      done_sim = 1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
